// File: rtl/demux2_pkg.sv
// Shared constants and types for the two-way stream demultiplexer.
// The counter feature is selected by the DEMUX2_CNT_EN macro in demux2_stream.
package demux2_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 2;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic {
    DEST_A = 1'b0,
    DEST_B = 1'b1
  } dest_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    dest_e                 sel;
  } beat_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head entry visible combinationally.
// Head data is forced to zero while empty so outputs read 0 straight out of reset.
module sync_fifo
  import demux2_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push_ok, pop_ok;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/demux2_stream.sv
// Steers one input byte stream into per-output FIFOs A/B under a per-beat select.
// Define DEMUX2_CNT_EN to add the a_cnt_o/b_cnt_o completed-transfer counters.
module demux2_stream
  import demux2_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
`ifdef DEMUX2_CNT_EN
  , parameter int CNT_W = CNT_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_sel_i,
  output logic              in_ready_o,
  output logic              a_valid_o,
  output logic [DATA_W-1:0] a_data_o,
  input  logic              a_ready_i,
  output logic              b_valid_o,
  output logic [DATA_W-1:0] b_data_o,
  input  logic              b_ready_i
`ifdef DEMUX2_CNT_EN
  , output logic [CNT_W-1:0] a_cnt_o,
  output logic [CNT_W-1:0]   b_cnt_o
`endif
);

  dest_e dest;
  logic  a_full, a_empty, b_full, b_empty;
  logic  a_push, b_push, a_pop, b_pop;

  assign dest = dest_e'(in_sel_i);

  // Ready depends only on the selected FIFO's registered state: no pass-through when full.
  assign in_ready_o = (dest == DEST_B) ? !b_full : !a_full;
  assign a_push     = in_valid_i && in_ready_o && (dest == DEST_A);
  assign b_push     = in_valid_i && in_ready_o && (dest == DEST_B);
  assign a_valid_o  = !a_empty;
  assign b_valid_o  = !b_empty;
  assign a_pop      = a_valid_o && a_ready_i;
  assign b_pop      = b_valid_o && b_ready_i;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_a (
    .clk         (clk),
    .reset       (reset),
    .push_i      (a_push),
    .push_data_i (in_data_i),
    .pop_i       (a_pop),
    .pop_data_o  (a_data_o),
    .full_o      (a_full),
    .empty_o     (a_empty)
  );

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_b (
    .clk         (clk),
    .reset       (reset),
    .push_i      (b_push),
    .push_data_i (in_data_i),
    .pop_i       (b_pop),
    .pop_data_o  (b_data_o),
    .full_o      (b_full),
    .empty_o     (b_empty)
  );

`ifdef DEMUX2_CNT_EN
  logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
  logic [CNT_W-1:0] b_cnt_q, b_cnt_d;

  always_comb begin
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    if (a_pop) a_cnt_d = a_cnt_q + 1'b1;
    if (b_pop) b_cnt_d = b_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  assign a_cnt_o = a_cnt_q;
  assign b_cnt_o = b_cnt_q;
`endif

endmodule

// File: doc/demux2_stream.md
# demux2_stream

Two-way stream demultiplexer with per-output buffering: the companion to the team's 8-bit 2:1 mux, steering one input byte stream onto one of two output channels under a per-beat select. Each output owns a small FIFO, so a stalled consumer on one side never corrupts or reorders the other side's traffic. It sits between a single producer (e.g. a packet source) and two independent consumers.

## Interface
- DATA_W, 8, width of every data path
- DEPTH, 2, entries per output FIFO; power of two, ≥ 2
- CNT_W, 16, width of the per-output transfer counters (used only with DEMUX2_CNT_EN)

- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid_i  input  1  input beat valid
- in_data_i  input  DATA_W  input beat data
- in_sel_i  input  1  destination: 0 → A, 1 → B; sampled with the beat
- in_ready_o  output  1  input beat accepted this cycle if in_valid_i is also high
- a_valid_o / b_valid_o  output  1  output FIFO non-empty
- a_data_o / b_data_o  output  DATA_W  head-of-FIFO data
- a_ready_i / b_ready_i  input  1  consumer accepts head entry
- a_cnt_o / b_cnt_o  output  CNT_W  completed output transfers (DEMUX2_CNT_EN only)

## Operation
- Input handshake: a beat transfers when in_valid_i && in_ready_o; it is pushed into FIFO[in_sel_i].
- in_ready_o = !full[in_sel_i], combinational from in_sel_i and registered FIFO state; no dependence on a_ready_i/b_ready_i (no pass-through when full).
- Output handshake: pop when x_valid_o && x_ready_i; x_valid_o = !empty; x_data_o = entry at read pointer; x_data_o is don't-care when x_valid_o low.
- Each FIFO: read/write pointers of log2(DEPTH)+1 bits; full when lower bits equal and MSBs differ; empty when pointers equal; pointers wrap naturally.
- Simultaneous push and pop on the same FIFO: both occur; occupancy unchanged. On a full FIFO, push is refused (in_ready_o low) even if a pop occurs that cycle.
- Per-output order is strictly preserved; no ordering relation between A and B.
- Producer may change in_sel_i/in_data_i while in_valid_i low; while in_valid_i high and in_ready_o low, the producer holds all inputs (bench asserts this).
- Counters: x_cnt_o increments by 1 per output transfer, wraps from 2^CNT_W−1 to 0.

## Timing
- Reset: both FIFOs empty, a_valid_o = b_valid_o = 0, counters = 0; in_ready_o = 1 in the first cycle after reset deasserts. Data outputs reset to 0.
- Reset mid-operation discards all buffered beats; no output valid in the cycle following the reset edge.
- Latency: beat accepted at edge N appears on x_valid_o/x_data_o after edge N (visible in cycle N+1); one-cycle minimum latency.
- Throughput: one beat per cycle sustained to either output while that consumer holds ready high.
- Counter reflects a transfer from the cycle after the handshake edge.

## Configuration
- DEMUX2_CNT_EN defined: a_cnt_o/b_cnt_o ports and counter registers present, behaving as above.
- Not defined: the counter ports are absent from the port list and no counter logic is generated; all other behaviour identical.

## Structure
- Package demux2_pkg: default DATA_W/DEPTH/CNT_W constants, dest_e enum (DEST_A = 0, DEST_B = 1), and a beat_t struct {data, sel} for bench use.
- Sub-module sync_fifo (parameters DATA_W, DEPTH; push/pop/full/empty/data ports, synchronous active-high reset), instantiated twice; top holds steering and counters only.

## Test plan
- Reset check: hold reset 2 cycles, release → a_valid_o = b_valid_o = 0, in_ready_o = 1, counters 0.
- Steering: push 0x11 sel 0, 0x22 sel 1, consumers ready → A emits 0x11, B emits 0x22 one cycle after each accept; a_cnt_o = b_cnt_o = 1.
- Back-pressure: b_ready_i = 0, push 0xA0, 0xA1 sel 1 → in_ready_o low for sel 1, high for sel 0; push 0x55 sel 0 still accepted and delivered on A; then release b_ready_i → B emits 0xA0, 0xA1 in order.
- Full with simultaneous pop: B full (DEPTH = 2), b_ready_i = 1, in_valid_i with sel 1 → pop happens, push refused that cycle, accepted the next.
- Wrap: stream 20 beats 0x00..0x13 to A with random a_ready_i → all 20 emitted in order; a_cnt_o = 20.
- Reset mid-stream: B holding 2 beats, assert reset 1 cycle → b_valid_o = 0, counters 0, no stale 0xA0/0xA1 emitted afterward.
